// File: rtl/noc_pkg.sv
// Shared types and sizing helpers for the credit-based NoC link arbiter.
// The default credit count covers a 16-entry RAM plus the buffer's output register.
package noc_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_BUF_DEPTH = 16;
  localparam int DEFAULT_CREDITS   = DEFAULT_BUF_DEPTH + 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_credit_link_arbiter_if.sv
// Requester-side handshake, link output and credit signals of the link arbiter.
// The master modport is the arbiter; slave is the surrounding router/testbench.
interface noc_credit_link_arbiter_if
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int N_IN       = 4,
  parameter int CREDITS    = DEFAULT_CREDITS
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int IW = idx_width(N_IN);

  logic [N_IN*FLIT_WIDTH-1:0] in_flit;
  logic [N_IN-1:0]            in_last;
  logic [N_IN-1:0]            in_valid;
  logic [N_IN-1:0]            in_ready;
  logic [FLIT_WIDTH-1:0]      out_flit;
  logic                       out_last;
  logic                       out_valid;
  logic                       credit_ret;
  logic [CW-1:0]              credits;
  logic [IW-1:0]              grant_id;
  logic                       credit_err;

  modport master (
    input  in_flit, in_last, in_valid, credit_ret,
    output in_ready, out_flit, out_last, out_valid, credits, grant_id, credit_err
  );

  modport slave (
    output in_flit, in_last, in_valid, credit_ret,
    input  in_ready, out_flit, out_last, out_valid, credits, grant_id, credit_err
  );

endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin pick: first asserted request found cyclically from rr_ptr_i.
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int IW  = idx_width(N_IN)
) (
  input  logic [N_IN-1:0] req_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic [N_IN-1:0] gnt_oh_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            gnt_valid_o
);

  int idx;

  always_comb begin
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int k = 0; k < N_IN; k++) begin
      idx = (int'(rr_ptr_i) + k) % N_IN;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o   = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_credit_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one credit-flow-controlled NoC link.
// Holds the link for a whole packet, registers the outgoing flit, and tracks downstream slots.
module noc_credit_link_arbiter
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int N_IN       = 4,
  parameter int CREDITS    = DEFAULT_CREDITS,
  localparam int CW        = $clog2(CREDITS + 1),
  localparam int IW        = idx_width(N_IN)
) (
  input logic                     clk,
  input logic                     rst,
  noc_credit_link_arbiter_if.master bus
);

  arb_state_t            state_q;
  logic [IW-1:0]         rr_ptr_q;
  logic [IW-1:0]         grant_id_q;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  credit_err_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [FLIT_WIDTH-1:0] out_flit_q;

  logic [N_IN-1:0]       rr_oh;
  logic [IW-1:0]         rr_idx;
  logic                  rr_valid;

  logic [N_IN-1:0]       sel_oh;
  logic [IW-1:0]         sel_idx;
  logic                  sel_valid;
  logic [N_IN-1:0]       ready_vec;
  logic                  accept;
  logic                  acc_last;
  logic [FLIT_WIDTH-1:0] acc_flit;

  noc_rr_arbiter #(.N_IN(N_IN)) u_rr (
    .req_i      (bus.in_valid),
    .rr_ptr_i   (rr_ptr_q),
    .gnt_oh_o   (rr_oh),
    .gnt_idx_o  (rr_idx),
    .gnt_valid_o(rr_valid)
  );

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(N_IN - 1)) ? '0 : i + 1'b1;
  endfunction

  // While locked only the packet owner is eligible; zero credits block every requester.
  always_comb begin
    sel_oh    = '0;
    sel_idx   = grant_id_q;
    sel_valid = 1'b0;
    if (state_q == IDLE) begin
      sel_oh    = rr_oh;
      sel_idx   = rr_idx;
      sel_valid = rr_valid;
    end else begin
      sel_oh[grant_id_q] = 1'b1;
      sel_valid          = bus.in_valid[grant_id_q];
    end
    ready_vec = (sel_valid && (credits_q != '0)) ? sel_oh : '0;
    accept    = |ready_vec;
    acc_last  = bus.in_last[sel_idx];
    acc_flit  = bus.in_flit[sel_idx*FLIT_WIDTH +: FLIT_WIDTH];
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !bus.credit_ret) begin
      credits_d = credits_q - 1'b1;
    end else if (!accept && bus.credit_ret && (credits_q != CW'(CREDITS))) begin
      credits_d = credits_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      credits_q    <= CW'(CREDITS);
      credit_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_flit_q   <= '0;
    end else begin
      credits_q   <= credits_d;
      out_valid_q <= accept;
      if (!accept && bus.credit_ret && (credits_q == CW'(CREDITS))) begin
        credit_err_q <= 1'b1;
      end
      if (accept) begin
        out_flit_q <= acc_flit;
        out_last_q <= acc_last;
        grant_id_q <= sel_idx;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (acc_last) begin
              rr_ptr_q <= next_idx(sel_idx);
            end else begin
              state_q <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (accept && acc_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_idx(grant_id_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = ready_vec;
  assign bus.out_flit   = out_flit_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.credits    = credits_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_credit_link_arbiter.sv
// Directed bench for noc_credit_link_arbiter: arbitration order, packet locking,
// credit exhaustion/return, full-rate streaming at one credit, and reset behaviour.
module tb_noc_credit_link_arbiter;

  logic clk;
  logic rst;

  int checkCount = 0;
  int passCount  = 0;
  int stepNum    = 0;
  int s          = 0;
  int acceptCnt  = 0;

  noc_credit_link_arbiter_if #(.FLIT_WIDTH(32), .N_IN(4), .CREDITS(17)) bus ();

  noc_credit_link_arbiter #(.FLIT_WIDTH(32), .N_IN(4), .CREDITS(17)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] flitOf(input int r, input int st);
    return {12'hF00, 4'(r), 16'(st)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last, input logic cret);
    logic [127:0] flits;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stepNum++;
    for (int i = 0; i < 4; i++) flits[i*32 +: 32] = flitOf(i, stepNum);
    bus.in_flit    = flits;
    bus.in_valid   = valid;
    bus.in_last    = last;
    bus.credit_ret = cret;
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    bus.in_flit    = '0;
    bus.in_valid   = '0;
    bus.in_last    = '0;
    bus.credit_ret = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_flit    = '0;
    bus.in_valid   = '0;
    bus.in_last    = '0;
    bus.credit_ret = 1'b0;
    doReset();

    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("rst_credits", 32'(bus.credits), 32'd17);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("rst_out_flit", bus.out_flit, 32'd0);
    checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("rst_credit_err", 32'(bus.credit_err), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);

    // Requester 3 sends a 3-flit packet; rr_ptr wraps from 3 to 0 afterwards.
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    s = stepNum;
    checkOutput("p3_f1_ready", 32'(bus.in_ready), 32'b1000);
    checkOutput("p3_f1_credits", 32'(bus.credits), 32'd17);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkOutput("p3_f2_ready", 32'(bus.in_ready), 32'b1000);
    checkOutput("p3_f1_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("p3_f1_out_flit", bus.out_flit, flitOf(3, s));
    checkOutput("p3_f1_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("p3_f1_grant", 32'(bus.grant_id), 32'd3);
    checkOutput("p3_f2_credits", 32'(bus.credits), 32'd16);
    s = stepNum;
    applyStimulus(4'b1000, 4'b1000, 1'b0);
    checkOutput("p3_f3_ready", 32'(bus.in_ready), 32'b1000);
    checkOutput("p3_f2_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("p3_f2_out_flit", bus.out_flit, flitOf(3, s));
    checkOutput("p3_f3_credits", 32'(bus.credits), 32'd15);
    s = stepNum;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("p3_done_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("p3_f3_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("p3_f3_out_last", 32'(bus.out_last), 32'd1);
    checkOutput("p3_f3_out_flit", bus.out_flit, flitOf(3, s));
    checkOutput("p3_done_credits", 32'(bus.credits), 32'd14);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("p3_idle_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("p3_hold_out_last", 32'(bus.out_last), 32'd1);
    checkOutput("p3_hold_out_flit", bus.out_flit, flitOf(3, s));

    // Requesters 0 and 2 with 2-flit packets, then single-flit packets, rr_ptr starting at 0.
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    checkOutput("rr_a1_ready", 32'(bus.in_ready), 32'b0001);
    applyStimulus(4'b0101, 4'b0001, 1'b0);
    checkOutput("rr_a2_ready_locked", 32'(bus.in_ready), 32'b0001);
    s = stepNum;
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    checkOutput("rr_a3_ready", 32'(bus.in_ready), 32'b0100);
    checkOutput("rr_a2_out_last", 32'(bus.out_last), 32'd1);
    checkOutput("rr_a2_out_flit", bus.out_flit, flitOf(0, s));
    checkOutput("rr_a2_grant", 32'(bus.grant_id), 32'd0);
    applyStimulus(4'b0101, 4'b0100, 1'b0);
    checkOutput("rr_a4_ready_locked", 32'(bus.in_ready), 32'b0100);
    checkOutput("rr_a3_grant", 32'(bus.grant_id), 32'd2);
    applyStimulus(4'b0101, 4'b0101, 1'b0);
    checkOutput("rr_a5_ready_wrap", 32'(bus.in_ready), 32'b0001);
    applyStimulus(4'b0101, 4'b0101, 1'b0);
    checkOutput("rr_a6_ready", 32'(bus.in_ready), 32'b0100);
    checkOutput("rr_a5_grant", 32'(bus.grant_id), 32'd0);
    s = stepNum;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("rr_a6_out_flit", bus.out_flit, flitOf(2, s));
    checkOutput("rr_a6_grant", 32'(bus.grant_id), 32'd2);
    checkOutput("rr_credits", 32'(bus.credits), 32'd8);

    // Credit exhaustion: requester 1 streams 20 single-flit packets with no returns.
    doReset();
    acceptCnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(4'b0010, 4'b0010, 1'b0);
      if (bus.in_ready[1]) acceptCnt++;
    end
    checkOutput("exh_accepts", 32'(acceptCnt), 32'd17);
    checkOutput("exh_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("exh_credits", 32'(bus.credits), 32'd0);
    applyStimulus(4'b0010, 4'b0010, 1'b1);
    checkOutput("exh_ret_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    checkOutput("exh_one_ready", 32'(bus.in_ready), 32'b0010);
    checkOutput("exh_one_credits", 32'(bus.credits), 32'd1);
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    checkOutput("exh_again_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("exh_again_credits", 32'(bus.credits), 32'd0);

    // Full-rate streaming with one credit: accept and return in the same cycle.
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    acceptCnt = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      if (bus.in_ready[1]) acceptCnt++;
      checkOutput("one_credit_level", 32'(bus.credits), 32'd1);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("one_credit_accepts", 32'(acceptCnt), 32'd10);
    checkOutput("one_credit_final", 32'(bus.credits), 32'd1);

    // Lock hold: requester 3 bubbles mid-packet while requester 0 waits.
    doReset();
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkOutput("lock_b1_ready", 32'(bus.in_ready), 32'b1000);
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    checkOutput("lock_b2_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    checkOutput("lock_b3_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(4'b1001, 4'b0001, 1'b0);
    checkOutput("lock_b4_ready", 32'(bus.in_ready), 32'b1000);
    applyStimulus(4'b1001, 4'b1001, 1'b0);
    checkOutput("lock_b5_ready", 32'(bus.in_ready), 32'b1000);
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    checkOutput("lock_b6_ready", 32'(bus.in_ready), 32'b0001);
    checkOutput("lock_b6_out_last", 32'(bus.out_last), 32'd1);
    checkOutput("lock_b6_grant", 32'(bus.grant_id), 32'd3);
    checkOutput("lock_b6_credits", 32'(bus.credits), 32'd14);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkOutput("lock_b7_ready", 32'(bus.in_ready), 32'b1000);

    // Reset while locked, then a surplus credit return.
    doReset();
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("mrst_credits", 32'(bus.credits), 32'd17);
    checkOutput("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mrst_credit_err", 32'(bus.credit_err), 32'd0);
    applyStimulus(4'b0001, 4'b0001, 1'b0);
    checkOutput("mrst_err_set", 32'(bus.credit_err), 32'd1);
    checkOutput("mrst_credits_sat", 32'(bus.credits), 32'd17);
    checkOutput("mrst_idle_ready", 32'(bus.in_ready), 32'b0001);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("mrst_err_sticky", 32'(bus.credit_err), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/noc_credit_link_arbiter.md
Name: noc_credit_link_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one NoC link among N requesters; the link feeds one downstream noc input buffer.
- Flow control is credit-based. Credits start at the downstream buffer capacity, are spent per flit sent, and are returned by the buffer's registered one-cycle ready pulse. Each returned credit is one freed slot.
- Sits at a router output port: input-side FIFOs on one side, link register on the other. There is no out_ready.

Parameters:
- FLIT_WIDTH, 32, flit payload width.
- N_IN, 4, number of requesters (>=2).
- CREDITS, 17, initial and maximum credits. Equals downstream DEPTH+1 (16-entry RAM plus output register).
- CW, $clog2(CREDITS+1), credit counter width (localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_flit  in  N_IN*FLIT_WIDTH  requester flits, slice i = requester i.
- in_last  in  N_IN  last-flit-of-packet flags.
- in_valid  in  N_IN  requester valid.
- in_ready  out  N_IN  accept strobe, combinational, one-hot or zero.
- out_flit  out  FLIT_WIDTH  registered link flit.
- out_last  out  1  registered link last flag.
- out_valid  out  1  registered link valid, single-cycle per flit.
- credit_ret  in  1  credit return pulse from downstream (its in_ready).
- credits  out  CW  current credit count.
- grant_id  out  $clog2(N_IN)  requester currently owning or last owning the link.
- credit_err  out  1  sticky: credit returned while counter == CREDITS.

Behaviour:
- Reset values (synchronous on rst=1; a reset mid-packet drops the packet):
  - state=IDLE, rr_ptr=0, grant_id=0
  - credits=CREDITS, credit_err=0
  - out_valid=0, out_last=0, out_flit=0
- Send condition: a flit is accepted when in_valid[g] & in_ready[g]. in_ready[g] = (credits!=0) & in_valid[g] & (g is the selected requester).
- IDLE state:
  - Winner is the first i with in_valid[i]=1, searching cyclically from rr_ptr.
  - If credits==0, no grant and no state change.
  - On accept with in_last=1: stay IDLE, rr_ptr=winner+1 mod N_IN.
  - On accept with in_last=0: go to LOCKED, grant_id=winner.
  - grant_id updates on every accept.
- LOCKED state:
  - Only grant_id is eligible; other valids are ignored.
  - Bubbles (in_valid low) or zero credits hold the lock.
  - Accept with in_last=1: go to IDLE, rr_ptr=grant_id+1 mod N_IN.
- Link output: registered, latency 1. The cycle after an accept, out_valid=1 and out_flit/out_last carry the accepted flit. Otherwise out_valid=0; out_flit and out_last hold their values.
- Credit counter:
  - accept only: credits-1.
  - credit_ret only: credits+1.
  - Both in the same cycle: unchanged. This allows full-rate streaming at credits==1.
  - credit_ret with credits==CREDITS and no accept: counter saturates and credit_err is set (sticky until rst).
  - credits never underflows, because in_ready is gated by credits!=0.
- Wrap-around: rr_ptr increments modulo N_IN. grant N_IN-1 gives next pointer 0.
- Throughput: at most one flit per cycle. Back-to-back packets from different requesters are allowed without an idle cycle.

Decomposition:
- Package noc_pkg:
  - enum arb_state_t {IDLE, LOCKED}
  - function for the requester index width
  - localparam default credit count (DEPTH+1 rule)
- Sub-module noc_rr_arbiter (N_IN): combinational request vector plus rr_ptr in, one-hot grant plus index out.
- Credit counter, lock FSM and link register stay in the top module.

Test Plan:
- Single requester, 3-flit packet with ample credits: in_ready high 3 cycles; out_valid high cycles 1-3 after the first accept; out_last on the 3rd; credits 17->14.
- Requesters 0 and 2 both valid with 2-flit packets, rr_ptr=0: packet 0 is sent fully before any flit of 2, then packet 2 is sent; rr_ptr ends at 3. Valids kept high thereafter: next grant order 0 then 2 (wrap via 3 to 0).
- No credit_ret, requester 1 streams 20 single-flit packets: exactly 17 accepts, then in_ready=0 and credits=0. One credit_ret pulse gives exactly one more accept.
- credits==1 with simultaneous accept and credit_ret each cycle for 10 cycles: 10 flits sent, credits stays 1.
- Lock hold: requester 3 mid-packet deasserts valid for 2 cycles while requester 0 is valid. Requester 0 gets no in_ready until requester 3's last flit is accepted.
- rst asserted while LOCKED, then credit_ret at credits=17: state IDLE, credits=17, out_valid=0 after reset; the extra return sets credit_err=1 and credits stays 17.
